// File: rtl/beep_player_if.sv
// Note-period stream from the note LUT into beep_player.
`default_nettype none

interface beep_player_if #(
  parameter int PW = 32
);
  logic [PW-1:0] period_in;
  logic          period_vld;
  logic          period_rdy;

  modport master (output period_in, output period_vld, input period_rdy);
  modport slave  (input period_in, input period_vld, output period_rdy);
endinterface

`default_nettype wire

// File: rtl/beep_player.sv
// ---------------------------------------------------------------------------
// beep_player : square-wave tone player, one fixed-length note per period word
// Optional macro TONE_GAP_EN adds a silent GAP after every note.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module beep_player #(
  parameter int NOTE_CYCLES = 12_500_000,
  parameter int GAP_CYCLES  = 1_250_000,
  parameter int PW          = 32
) (
  input  logic               clk,
  input  logic               rst,
  beep_player_if.slave       bus,
  output logic               beep,
  output logic               note_done,
  output logic               busy
);

  localparam int MAXC = (NOTE_CYCLES > GAP_CYCLES) ? NOTE_CYCLES : GAP_CYCLES;
  localparam int DW   = $clog2(MAXC + 1);
  localparam logic [DW-1:0] NOTE_LAST = DW'(NOTE_CYCLES - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_PLAY = 2'd1;
`ifdef TONE_GAP_EN
  localparam logic [1:0] S_GAP  = 2'd2;
  localparam logic [DW-1:0] GAP_LAST = DW'(GAP_CYCLES - 1);
`endif

  logic [1:0]    state_q,  state_d;
  logic [PW-1:0] period_q, period_d;
  logic [PW-1:0] half_q,   half_d;
  logic [PW-1:0] tone_q,   tone_d;
  logic [DW-1:0] dur_q,    dur_d;
  logic          beep_q,   beep_d;
  logic          done_q,   done_d;
  logic [PW-1:0] tone_nxt;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      period_q <= '0;
      half_q   <= '0;
      tone_q   <= '0;
      dur_q    <= '0;
      beep_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      period_q <= period_d;
      half_q   <= half_d;
      tone_q   <= tone_d;
      dur_q    <= dur_d;
      beep_q   <= beep_d;
      done_q   <= done_d;
    end
  end

  // beep is registered, so it is computed from the phase of the coming cycle
  always_comb begin
    state_d  = state_q;
    period_d = period_q;
    half_d   = half_q;
    tone_d   = tone_q;
    dur_d    = dur_q;
    beep_d   = 1'b0;
    done_d   = 1'b0;
    tone_nxt = (tone_q == period_q - PW'(1)) ? '0 : tone_q + PW'(1);
    case (state_q)
      S_IDLE: begin
        if (bus.period_vld) begin
          state_d  = S_PLAY;
          period_d = bus.period_in;
          half_d   = bus.period_in >> 1;
          tone_d   = '0;
          dur_d    = '0;
          beep_d   = (bus.period_in >= PW'(2));
        end
      end
      S_PLAY: begin
        if (dur_q == NOTE_LAST) begin
          done_d = 1'b1;
          dur_d  = '0;
          tone_d = '0;
`ifdef TONE_GAP_EN
          state_d = S_GAP;
`else
          state_d = S_IDLE;
`endif
        end else begin
          dur_d  = dur_q + DW'(1);
          tone_d = tone_nxt;
          beep_d = (period_q >= PW'(2)) && (tone_nxt < half_q);
        end
      end
`ifdef TONE_GAP_EN
      S_GAP: begin
        if (dur_q == GAP_LAST) begin
          state_d = S_IDLE;
          dur_d   = '0;
        end else begin
          dur_d = dur_q + DW'(1);
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    bus.period_rdy = (state_q == S_IDLE);
    busy           = (state_q != S_IDLE);
    beep           = beep_q;
    note_done      = done_q;
  end

endmodule

`default_nettype wire

// File: doc/beep_player.md
# beep_player

- Tone generator that consumes note period words (clock cycles per tone period) from the note lookup table.
- Drives a 50%-duty square wave to the buzzer pin for a fixed note duration per word.
- Pulls the next word through a valid/ready handshake, so the table index advances only when a note is finished.
- Sits between the note LUT and the passive buzzer output.

## Interface
- NOTE_CYCLES, 12_500_000, note duration in clk cycles (250 ms at 50 MHz); legal range ≥ 1
- GAP_CYCLES, 1_250_000, silence inserted after each note when the gap feature is compiled in; legal range ≥ 1
- PW, 32, period word width
- clk  in  1  system clock; all logic on rising edge
- rst  in  1  reset, synchronous, active-low; only clock and reset are fixed: one clock, synchronous active-low reset
- period_in  in  PW  tone period in clk cycles; values < 2 denote a rest
- period_vld  in  1  period_in valid
- period_rdy  out  1  high only in IDLE; transfer when period_vld && period_rdy at a rising edge
- beep  out  1  registered square-wave output to the buzzer
- note_done  out  1  one-cycle pulse after each note's last PLAY cycle
- busy  out  1  high in PLAY and GAP

## Operation
- States: IDLE, PLAY, GAP (GAP exists only with the macro).
- IDLE:
  - beep=0, period_rdy=1.
  - On transfer, latch P=period_in and half=P>>1 (floor), clear tone_cnt and dur_cnt, go to PLAY.
- PLAY lasts exactly NOTE_CYCLES cycles, indexed k=0..NOTE_CYCLES-1.
  - If P≥2: beep=1 when (k mod P) < half, else 0. tone_cnt wraps from P-1 to 0.
  - If P<2 (rest): beep=0 for the whole note.
  - Odd P gives a high phase one cycle shorter than the low phase.
- The latched P is immune to period_in or period_vld activity during PLAY/GAP; no transfers occur outside IDLE.
- After the final PLAY cycle, go to GAP (macro) or IDLE (no macro). note_done=1 in that first following cycle only.
- GAP: beep=0, busy=1, lasts GAP_CYCLES cycles, then IDLE.
- Counters: tone_cnt is PW bits; dur_cnt is sized by $clog2 of max(NOTE_CYCLES,GAP_CYCLES)+1. No overflow is possible within legal parameters.
- Reset (rst=0 at an edge), including mid-PLAY/GAP:
  - Next cycle: state IDLE, beep=0, note_done=0, busy=0, period_rdy=1, counters 0.
  - The aborted note produces no note_done.

## Timing
- Reset values: beep=0, note_done=0, busy=0, period_rdy=1 (IDLE); latched P=0.
- Transfer at edge E: cycle after E is PLAY k=0, with beep=1 if P≥2 and busy=1.
- Latency from accept to first beep high: 1 cycle.
- Note occupies cycles E+1..E+NOTE_CYCLES. note_done is at cycle E+NOTE_CYCLES+1.
- Without the macro:
  - IDLE is entered at E+NOTE_CYCLES+1, with note_done=1 and period_rdy=1 in the same cycle.
  - A held period_vld transfers at the end of that cycle.
  - Back-to-back notes are therefore separated by exactly one beep=0 cycle.
- With the macro: GAP spans cycles E+NOTE_CYCLES+1 .. E+NOTE_CYCLES+GAP_CYCLES, and IDLE/period_rdy returns the cycle after.
- period_rdy is decoded from the state register, with no combinational path from period_vld.

## Configuration
- TONE_GAP_EN:
  - Defined: GAP state compiled in; each note is followed by GAP_CYCLES of silence with busy=1, giving audible articulation between repeated notes.
  - Undefined: no GAP state; GAP_CYCLES unused; PLAY→IDLE directly.

## Test plan
Parameters for all scenarios: NOTE_CYCLES=20, GAP_CYCLES=4, TONE_GAP_EN defined unless stated.
- Reset: hold rst=0 for 3 cycles with period_vld=1 → beep=0, busy=0, note_done=0, period_rdy=1, no transfer; first transfer occurs on the first edge with rst=1.
- Even period: P=4 → beep 1,1,0,0 repeated 5× over 20 cycles; note_done one cycle; 4 GAP cycles with beep=0 and busy=1; then period_rdy=1.
- Odd period and rest:
  - P=5 → beep 1,1,0,0,0 ×4.
  - P=0 → beep=0 for 20 cycles, busy=1, note_done still pulses once.
- Hold-off: period_in switched from 4 to 6 at PLAY k=7 with period_vld=1 → waveform stays P=4; P=6 is accepted only at the first IDLE cycle.
- Reset mid-note: rst=0 at PLAY k=7 → next cycle IDLE, beep=0, busy=0; no note_done ever issued for that note.
- Without TONE_GAP_EN: period_vld held high, P=4 then P=8 → exactly one beep=0 cycle between the notes; note_done and period_rdy coincide in that cycle.
